// File: rtl/nios_system_pio_rr_arbiter.sv
// nios_system_pio_rr_arbiter: round-robin sharing of one Avalon-MM PIO slave among NUM_MASTERS cores
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   m_chipselect/m_write_n          per-master request and active-low write strobe
//   m_address/m_writedata           packed per-master command fields
//   m_waitrequest/m_readdata        per-master stall, shared read data valid in RESP
//   s_chipselect/s_write_n/s_address/s_writedata/s_readdata   registered PIO side
//   grant_id                        current/last granted master
module nios_system_pio_rr_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 2,
  parameter int DATA_W      = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_MASTERS-1:0]          m_chipselect,
  input  logic [NUM_MASTERS-1:0]          m_write_n,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_address,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_writedata,
  output logic [NUM_MASTERS-1:0]          m_waitrequest,
  output logic [DATA_W-1:0]               m_readdata,
  output logic                            s_chipselect,
  output logic                            s_write_n,
  output logic [ADDR_W-1:0]               s_address,
  output logic [DATA_W-1:0]               s_writedata,
  input  logic [DATA_W-1:0]               s_readdata,
  output logic [$clog2(NUM_MASTERS)-1:0]  grant_id
);
  localparam int GW = $clog2(NUM_MASTERS);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] last_q, grant_q, pick, idx;
  logic [ADDR_W-1:0] addr_q, sel_addr;
  logic [DATA_W-1:0] wdata_q, rdata_q, sel_wdata;
  logic wn_q, sel_wn;
  // Scan offsets from farthest to nearest so the nearest requester after last_q wins.
  always_comb begin
    pick = '0;
    idx = '0;
    sel_addr = '0;
    sel_wdata = '0;
    sel_wn = 1'b1;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      idx = GW'((int'(last_q) + k) % NUM_MASTERS);
      if (m_chipselect[idx]) pick = idx;
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pick == GW'(i)) begin
        sel_addr = m_address[i*ADDR_W +: ADDR_W];
        sel_wdata = m_writedata[i*DATA_W +: DATA_W];
        sel_wn = m_write_n[i];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q <= GW'(NUM_MASTERS - 1);
      grant_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      wn_q <= 1'b1;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && |m_chipselect) begin
        grant_q <= pick;
        addr_q <= sel_addr;
        wdata_q <= sel_wdata;
        wn_q <= sel_wn;
      end
      if (state_q == ACCESS) rdata_q <= s_readdata;
      if (state_q == RESP) last_q <= grant_q;
    end
  end
  always_comb begin
    state_d = state_q == IDLE ? (|m_chipselect ? ACCESS : IDLE) : state_q == ACCESS ? RESP : IDLE;
  end
  always_comb begin
    s_chipselect = state_q == ACCESS;
    s_write_n = state_q == ACCESS ? wn_q : 1'b1;
    s_address = addr_q;
    s_writedata = wdata_q;
    m_readdata = rdata_q;
    grant_id = grant_q;
    m_waitrequest = m_chipselect;
    for (int i = 0; i < NUM_MASTERS; i++)
      m_waitrequest[i] = m_chipselect[i] & ~(state_q == RESP && grant_q == GW'(i));
  end
endmodule

// File: tb/tb_nios_system_pio_rr_arbiter.sv
// tb_nios_system_pio_rr_arbiter: scoreboard bench for the PIO round-robin arbiter
module tb_nios_system_pio_rr_arbiter;
  localparam int NM = 4;
  localparam int AW = 2;
  localparam int DW = 32;
  localparam int GW = 2;
  typedef struct {int id; logic [DW-1:0] rd; bit chk_rd; int lat;} exp_t;
  logic clk = 1'b0;
  logic reset;
  logic [NM-1:0] m_chipselect, m_write_n, m_waitrequest;
  logic [NM*AW-1:0] m_address;
  logic [NM*DW-1:0] m_writedata;
  logic [DW-1:0] m_readdata, s_writedata, s_readdata, out_port;
  logic s_chipselect, s_write_n;
  logic [AW-1:0] s_address;
  logic [GW-1:0] grant_id;
  exp_t sb[$];
  exp_t e;
  logic [NM-1:0] done;
  logic [DW-1:0] nxt[NM];
  int iss[NM];
  int rem[NM];
  int asserts = 0, fails = 0, cyc = 0, ndone = 0, n0 = 0, last_done = -1;
  bit chk_gap;
  nios_system_pio_rr_arbiter #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_address(m_address), .m_writedata(m_writedata), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .s_chipselect(s_chipselect), .s_write_n(s_write_n),
    .s_address(s_address), .s_writedata(s_writedata), .s_readdata(s_readdata),
    .grant_id(grant_id)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (reset) out_port <= '0;
    else if (s_chipselect && !s_write_n && s_address == 0) out_port <= s_writedata;
  assign s_readdata = (s_address == 0) ? out_port : '0;
  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    asserts++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic issue(input int i, input bit wn, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit push, input logic [DW-1:0] rd, input bit crd, input int lat);
    m_chipselect[i] = 1'b1;
    m_write_n[i] = wn;
    m_address[i*AW +: AW] = a;
    m_writedata[i*DW +: DW] = d;
    iss[i] = cyc;
    if (push) sb.push_back('{i, rd, crd, lat});
  endtask
  task automatic tick();
    @(negedge clk);
    done = m_chipselect & ~m_waitrequest;
    for (int i = 0; i < NM; i++) begin
      if (done[i]) begin
        ndone++;
        if (sb.size() == 0) check("sb_underflow", 32'(i), 32'hFFFF_FFFF);
        else begin
          e = sb.pop_front();
          check("grant_order", 32'(i), 32'(e.id));
          if (e.chk_rd) check("readdata", m_readdata, e.rd);
          if (e.lat > 0) check("latency", 32'(cyc - iss[i] + 1), 32'(e.lat));
          check("no_starve", 32'((cyc - iss[i] + 1) <= 3 * NM), 32'd1);
          if (chk_gap && last_done >= 0) check("gap", 32'(cyc - last_done), 32'd3);
        end
        last_done = cyc;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NM; i++) begin
      if (done[i]) begin
        if (rem[i] > 0) begin
          rem[i]--;
          nxt[i] = nxt[i] + 1;
          issue(i, 1'b0, '0, nxt[i], 1'b1, '0, 1'b0, 0);
        end else m_chipselect[i] = 1'b0;
      end
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    m_chipselect = '0;
    m_write_n = '1;
    m_address = '0;
    m_writedata = '0;
    for (int i = 0; i < NM; i++) rem[i] = 0;
    chk_gap = 1'b0;
    last_done = -1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_cs", 32'(s_chipselect), 32'd0);
    check("rst_s_wn", 32'(s_write_n), 32'd1);
    check("rst_s_addr", 32'(s_address), 32'd0);
    check("rst_s_wd", s_writedata, 32'd0);
    check("rst_m_rd", m_readdata, 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_wait", 32'(m_waitrequest), 32'd0);
    reset = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    do_reset();
    issue(0, 1'b0, 2'd0, 32'h1A5, 1'b1, '0, 1'b0, 3);
    check("t1_idle_cs", 32'(s_chipselect), 32'd0);
    tick();
    check("t1_acc_cs", 32'(s_chipselect), 32'd1);
    check("t1_acc_wn", 32'(s_write_n), 32'd0);
    check("t1_acc_wd", s_writedata, 32'h1A5);
    check("t1_grant", 32'(grant_id), 32'd0);
    check("t1_wait_acc", 32'(m_waitrequest[0]), 32'd1);
    tick();
    check("t1_wait_resp", 32'(m_waitrequest[0]), 32'd0);
    tick();
    check("t1_out", out_port, 32'h1A5);
    check("t1_drain", 32'(sb.size()), 32'd0);
    do_reset();
    chk_gap = 1'b1;
    for (int i = 0; i < NM; i++) issue(i, 1'b0, 2'd0, 32'(i + 1), 1'b1, '0, 1'b0, 3 * (i + 1));
    repeat (12) tick();
    check("t2_out", out_port, 32'h4);
    check("t2_drain", 32'(sb.size()), 32'd0);
    do_reset();
    chk_gap = 1'b1;
    rem[2] = 3;
    nxt[2] = 32'h20;
    issue(2, 1'b0, 2'd0, 32'h20, 1'b1, '0, 1'b0, 3);
    repeat (4) tick();
    issue(1, 1'b0, 2'd0, 32'h11, 1'b1, '0, 1'b0, 5);
    repeat (11) tick();
    check("t3_out", out_port, 32'h23);
    check("t3_drain", 32'(sb.size()), 32'd0);
    do_reset();
    issue(3, 1'b0, 2'd0, 32'h0F0, 1'b1, '0, 1'b0, 3);
    repeat (3) tick();
    check("t4_out", out_port, 32'h0F0);
    issue(3, 1'b1, 2'd0, '0, 1'b1, 32'h0F0, 1'b1, 3);
    repeat (3) tick();
    issue(3, 1'b1, 2'd1, '0, 1'b1, 32'h0, 1'b1, 3);
    repeat (3) tick();
    check("t4_drain", 32'(sb.size()), 32'd0);
    do_reset();
    issue(2, 1'b0, 2'd0, 32'h55, 1'b0, '0, 1'b0, 0);
    tick();
    check("t5_acc_cs", 32'(s_chipselect), 32'd1);
    check("t5_acc_grant", 32'(grant_id), 32'd2);
    reset = 1'b1;
    n0 = ndone;
    tick();
    check("t5_rst_cs", 32'(s_chipselect), 32'd0);
    check("t5_rst_wn", 32'(s_write_n), 32'd1);
    check("t5_rst_grant", 32'(grant_id), 32'd0);
    check("t5_rst_wait", 32'(m_waitrequest), 32'b0100);
    tick();
    check("t5_rst_wait2", 32'(m_waitrequest), 32'b0100);
    check("t5_no_resp", 32'(ndone - n0), 32'd0);
    reset = 1'b0;
    issue(0, 1'b0, 2'd0, 32'h77, 1'b1, '0, 1'b0, 3);
    issue(2, 1'b0, 2'd0, 32'h56, 1'b1, '0, 1'b0, 6);
    repeat (6) tick();
    check("t5_out", out_port, 32'h56);
    check("t5_drain", 32'(sb.size()), 32'd0);
    do_reset();
    issue(1, 1'b0, 2'd0, 32'h66, 1'b0, '0, 1'b0, 0);
    tick();
    m_chipselect[1] = 1'b0;
    tick();
    check("t6_resp_grant", 32'(grant_id), 32'd1);
    check("t6_resp_wait", 32'(m_waitrequest), 32'd0);
    check("t6_resp_cs", 32'(s_chipselect), 32'd0);
    tick();
    check("t6_out", out_port, 32'h66);
    issue(0, 1'b1, 2'd0, '0, 1'b1, 32'h66, 1'b1, 3);
    repeat (3) tick();
    check("t6_drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
